// File: rtl/cea861d_timing_detector.sv
// cea861d_timing_detector: CEA-861-D sync/de timing measurement, lock and pixel coordinates; TIMING_DETECT_ERR_CNT_EN enables err_cnt_o
module cea861d_timing_detector #(
  parameter int TOTAL_X      = 2200,
  parameter int TOTAL_Y      = 1125,
  parameter int ACTIVE_X     = 1920,
  parameter int ACTIVE_LINES = 1080,
  parameter int HSYNC_WIDTH  = 44,
  parameter int VSYNC_WIDTH  = 5,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        de_i,
  output logic        de_o,
  output logic [11:0] x_o,
  output logic [10:0] y_o,
  output logic        sof_o,
  output logic        locked_o,
  output logic        timing_err_o,
  output logic [11:0] meas_total_x_o,
  output logic [10:0] meas_total_y_o,
  output logic [11:0] meas_active_x_o,
  output logic [10:0] meas_lines_o,
  output logic [15:0] err_cnt_o
);
  localparam logic [11:0] TX = 12'(TOTAL_X);
  localparam logic [11:0] AX = 12'(ACTIVE_X);
  localparam logic [11:0] HW = 12'(HSYNC_WIDTH);
  localparam logic [10:0] TY = 11'(TOTAL_Y);
  localparam logic [10:0] AL = 11'(ACTIVE_LINES);
  localparam logic [10:0] VW = 11'(VSYNC_WIDTH);
  localparam int WD = 2 * TOTAL_Y * TOTAL_X;
  localparam int WW = $clog2(WD);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state, state_n;
  logic hs_r, vs_r, de_r, hs_p, vs_p, de_p;
  logic hs_rise, hs_fall, vs_rise, vs_fall, de_rise, de_fall;
  logic hs_seen, first, line_bad, bad_now, match, wd_fire, err_q, err_n;
  logic [11:0] px, px_inc, hw, ax, line_len, hs_width, act_x, len_cur, hw_cur, ax_cur, x_cnt;
  logic [10:0] ln, ln_inc, vw, al, vs_width, y_cnt;
  logic [WW-1:0] wd;
  logic [GW-1:0] good, good_n;
  assign hs_rise = hs_r & ~hs_p;
  assign hs_fall = ~hs_r & hs_p;
  assign vs_rise = vs_r & ~vs_p;
  assign vs_fall = ~vs_r & vs_p;
  assign de_rise = de_r & ~de_p;
  assign de_fall = ~de_r & de_p;
  assign px_inc = &px ? px : px + 1'b1;
  assign ln_inc = &ln ? ln : ln + 1'b1;
  assign len_cur = hs_rise & hs_seen ? px_inc : line_len;
  assign hw_cur = hs_fall ? hw : hs_width;
  assign ax_cur = de_fall ? ax : act_x;
  assign bad_now = line_bad | (hs_rise & hs_seen & (px_inc != TX)) | (hs_fall & (hw != HW)) | (de_fall & (ax != AX));
  assign match = (len_cur == TX) & (ln_inc == TY) & (ax_cur == AX) & (al == AL) & (hw_cur == HW) & (vs_width == VW) & ~bad_now;
  assign wd_fire = wd == WW'(WD - 1);
  assign de_o = de_r;
  assign x_o = de_rise ? '0 : x_cnt;
  assign y_o = de_rise ? (first ? '0 : y_cnt + 1'b1) : y_cnt;
  assign sof_o = de_rise & first & (state == LOCKED);
  assign locked_o = state == LOCKED;
  assign timing_err_o = err_q;
  always_comb begin
    state_n = state;
    good_n = good;
    err_n = 1'b0;
    if (vs_rise) begin
      if (state == SEARCH) begin
        state_n = MEASURE;
        good_n = '0;
      end else if (!match) begin
        state_n = MEASURE;
        good_n = '0;
        err_n = 1'b1;
      end else if (state == MEASURE) begin
        good_n = good + 1'b1;
        state_n = good_n == GW'(LOCK_FRAMES) ? LOCKED : MEASURE;
      end
    end else if (wd_fire && state != SEARCH) begin
      state_n = SEARCH;
      good_n = '0;
      err_n = 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {hs_r, vs_r, de_r, hs_p, vs_p, de_p} <= '0;
      {hs_seen, first, line_bad, err_q} <= '0;
      {px, hw, ax, line_len, hs_width, act_x, x_cnt} <= '0;
      {ln, vw, al, vs_width, y_cnt} <= '0;
      wd <= '0;
      good <= '0;
      state <= SEARCH;
      {meas_total_x_o, meas_total_y_o, meas_active_x_o, meas_lines_o} <= '0;
    end else begin
      {hs_r, vs_r, de_r} <= {hsync_i, vsync_i, de_i};
      {hs_p, vs_p, de_p} <= {hs_r, vs_r, de_r};
      px <= hs_rise ? '0 : px_inc;
      hs_seen <= hs_seen | hs_rise;
      line_len <= len_cur;
      hw <= hs_rise ? 12'd1 : hs_r & ~&hw ? hw + 1'b1 : hw;
      hs_width <= hw_cur;
      ax <= de_rise ? 12'd1 : de_r & ~&ax ? ax + 1'b1 : ax;
      act_x <= ax_cur;
      ln <= vs_rise ? '0 : hs_rise ? ln_inc : ln;
      vw <= vs_rise ? {10'd0, hs_rise} : vs_r & hs_rise & ~&vw ? vw + 1'b1 : vw;
      vs_width <= vs_fall ? vw : vs_width;
      al <= vs_rise ? {10'd0, de_rise} : de_rise & ~&al ? al + 1'b1 : al;
      line_bad <= ~vs_rise & bad_now;
      wd <= vs_rise | wd_fire ? '0 : wd + 1'b1;
      state <= state_n;
      good <= good_n;
      err_q <= err_n;
      first <= vs_rise | (first & ~de_rise);
      x_cnt <= de_r ? x_o + 1'b1 : x_cnt;
      y_cnt <= y_o;
      if (vs_rise) begin
        meas_total_x_o <= len_cur;
        meas_total_y_o <= ln_inc;
        meas_active_x_o <= ax_cur;
        meas_lines_o <= al;
      end
    end
  end
`ifdef TIMING_DETECT_ERR_CNT_EN
  always_ff @(posedge clk_i)
    err_cnt_o <= rst_i ? '0 : err_q & ~&err_cnt_o ? err_cnt_o + 1'b1 : err_cnt_o;
`else
  assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_cea861d_timing_detector.sv
// tb_cea861d_timing_detector: directed checks of lock, measurement, coordinates, watchdog and reset on a scaled-down raster
module tb_cea861d_timing_detector;
  localparam int TX = 20, AX = 12, HW = 3, TY = 10, AL = 6, VW = 2, LF = 2;
  localparam int HDE = 6, VDE = 3, WD = 2 * TX * TY;
`ifdef TIMING_DETECT_ERR_CNT_EN
  localparam int EXP_ERRS = 3;
`else
  localparam int EXP_ERRS = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic de_o, sof_o, locked_o, timing_err_o;
  logic [11:0] x_o, meas_total_x_o, meas_active_x_o;
  logic [10:0] y_o, meas_total_y_o, meas_lines_o;
  logic [15:0] err_cnt_o;
  int n_cmp = 0, n_bad = 0;
  int h = 0, v = 0, bad_v = -1, cyc = 0, vs_cyc = 0, err_cyc = 0;
  int de_cnt = 0, sof_cnt = 0, err_seen = 0, xy_bad = 0, last_x = 0, last_y = 0;
  bit sync_on = 1'b1, vs_prev = 1'b0, chk_xy = 1'b0;
  always #5 clk = ~clk;
  cea861d_timing_detector #(
    .TOTAL_X(TX), .TOTAL_Y(TY), .ACTIVE_X(AX), .ACTIVE_LINES(AL),
    .HSYNC_WIDTH(HW), .VSYNC_WIDTH(VW), .LOCK_FRAMES(LF)
  ) dut (
    .clk_i(clk), .rst_i(rst), .hsync_i(hsync), .vsync_i(vsync), .de_i(de),
    .de_o(de_o), .x_o(x_o), .y_o(y_o), .sof_o(sof_o), .locked_o(locked_o),
    .timing_err_o(timing_err_o), .meas_total_x_o(meas_total_x_o),
    .meas_total_y_o(meas_total_y_o), .meas_active_x_o(meas_active_x_o),
    .meas_lines_o(meas_lines_o), .err_cnt_o(err_cnt_o)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    hsync = sync_on && h < HW;
    vsync = sync_on && v < VW;
    de = sync_on && v >= VDE && v < VDE + AL && h >= HDE && h < HDE + AX;
    @(posedge clk);
    #1;
    cyc++;
    if (vsync && !vs_prev) vs_cyc = cyc;
    vs_prev = vsync;
    if (de_o) begin
      de_cnt++;
      last_x = int'(x_o);
      last_y = int'(y_o);
      if (chk_xy && (int'(x_o) != h - HDE || int'(y_o) != v - VDE)) xy_bad++;
    end
    sof_cnt += int'(sof_o);
    if (timing_err_o) begin
      err_seen++;
      err_cyc = cyc;
    end
    h++;
    if (h == (v == bad_v ? TX + 1 : TX)) begin
      h = 0;
      v = (v + 1) % TY;
    end
  endtask
  task automatic run_frame();
    step();
    while (h != 0 || v != 0) step();
  endtask
  task automatic clr();
    de_cnt = 0;
    sof_cnt = 0;
    err_seen = 0;
    xy_bad = 0;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_locked"}, int'(locked_o), 0);
    check({tag, "_de"}, int'(de_o), 0);
    check({tag, "_x"}, int'(x_o), 0);
    check({tag, "_y"}, int'(y_o), 0);
    check({tag, "_sof"}, int'(sof_o), 0);
    check({tag, "_err"}, int'(timing_err_o), 0);
    check({tag, "_mtx"}, int'(meas_total_x_o), 0);
    check({tag, "_mty"}, int'(meas_total_y_o), 0);
    check({tag, "_max"}, int'(meas_active_x_o), 0);
    check({tag, "_mln"}, int'(meas_lines_o), 0);
    check({tag, "_errcnt"}, int'(err_cnt_o), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    v = 5;
    repeat (3) step();
    check_zero("rst");
    rst = 1'b0;
    run_frame();
    clr(); run_frame();
    check("f1_locked", int'(locked_o), 0);
    clr(); run_frame();
    check("f2_locked", int'(locked_o), 0);
    check("f2_sof", sof_cnt, 0);
    check("f2_errs", err_seen, 0);
    check("meas_total_x", int'(meas_total_x_o), TX);
    check("meas_total_y", int'(meas_total_y_o), TY);
    check("meas_active_x", int'(meas_active_x_o), AX);
    check("meas_lines", int'(meas_lines_o), AL);
    chk_xy = 1'b1;
    clr(); run_frame();
    check("f3_locked", int'(locked_o), 1);
    check("f3_sof", sof_cnt, 1);
    check("f3_errs", err_seen, 0);
    check("f3_de_cnt", de_cnt, AX * AL);
    check("f3_last_x", last_x, AX - 1);
    check("f3_last_y", last_y, AL - 1);
    check("f3_xy", xy_bad, 0);
    bad_v = 7;
    clr(); run_frame();
    bad_v = -1;
    check("bad_frame_locked", int'(locked_o), 1);
    check("bad_frame_sof", sof_cnt, 1);
    clr(); run_frame();
    check("after_bad_err", err_seen, 1);
    check("after_bad_locked", int'(locked_o), 0);
    check("after_bad_sof", sof_cnt, 0);
    clr(); run_frame();
    check("relock1_locked", int'(locked_o), 0);
    clr(); run_frame();
    check("relock2_locked", int'(locked_o), 1);
    check("relock2_errs", err_seen, 0);
    check("relock2_xy", xy_bad, 0);
    clr();
    bad_v = 2;
    run_frame(); run_frame();
    bad_v = -1;
    run_frame();
    check("two_bad_errs", err_seen, 2);
    check("err_cnt", int'(err_cnt_o), EXP_ERRS);
    run_frame();
    check("relock3a_locked", int'(locked_o), 0);
    run_frame();
    check("relock3b_locked", int'(locked_o), 1);
    clr();
    sync_on = 1'b0;
    repeat (600) step();
    check("wd_errs", err_seen, 1);
    check("wd_delay", err_cyc - vs_cyc, WD + 1);
    check("wd_locked", int'(locked_o), 0);
    sync_on = 1'b1;
    h = 0;
    v = 0;
    run_frame(); run_frame(); run_frame();
    check("pre_rst_locked", int'(locked_o), 1);
    chk_xy = 1'b0;
    repeat (4 * TX + 10) step();
    rst = 1'b1;
    step();
    check_zero("midrst");
    rst = 1'b0;
    run_frame();
    run_frame();
    check("post_rst_f1_locked", int'(locked_o), 0);
    run_frame();
    check("post_rst_f2_locked", int'(locked_o), 0);
    chk_xy = 1'b1;
    clr(); run_frame();
    check("post_rst_f3_locked", int'(locked_o), 1);
    check("post_rst_sof", sof_cnt, 1);
    check("post_rst_de_cnt", de_cnt, AX * AL);
    check("post_rst_xy", xy_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
